// File: rtl/dpwm_monitor.sv
`timescale 1ns/1ps
// dpwm_monitor: recovers on-time, both dead-times and period of the complementary
// gate drives c1/c2 each switching period, and flags shoot-through and a stalled modulator.
module dpwm_monitor #(
  parameter int STALL_CYC = 4095
) (
  input  logic        i_clk,
  input  logic        reset,
  input  logic        i_enable,
  input  logic        i_c1,
  input  logic        i_c2,
  input  logic        i_clr_fault,
  output logic [10:0] o_ton,
  output logic [4:0]  o_dt1,
  output logic [4:0]  o_dt2,
  output logic [11:0] o_period,
  output logic        o_valid,
  output logic        o_overlap,
  output logic        o_stall
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    C1_ON = 3'd1,
    DT1   = 3'd2,
    C2_ON = 3'd3,
    DT2   = 3'd4
  } state_t;

  localparam logic [11:0] STALL_LIM = 12'(STALL_CYC);

  state_t      state;
  state_t      nxt;
  logic        s_c1, s_c2, d_c1, d_c2;
  logic        rise_c1, fall_c1, rise_c2, fall_c2;
  logic        close, start, stall_hit;
  logic [10:0] ton_cnt;
  logic [4:0]  dt1_cnt, dt2_cnt;
  logic [11:0] period_cnt;

  // Input sample register plus one-cycle-delayed copy for edge detection
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      {s_c1, s_c2, d_c1, d_c2} <= 4'b0000;
    end else begin
      s_c1 <= i_c1;
      s_c2 <= i_c2;
      d_c1 <= s_c1;
      d_c2 <= s_c2;
    end
  end

  assign rise_c1 = s_c1 & ~d_c1;
  assign fall_c1 = ~s_c1 & d_c1;
  assign rise_c2 = s_c2 & ~d_c2;
  assign fall_c2 = ~s_c2 & d_c2;

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Simultaneous fall/rise pairs skip the dead-time state so a zero-width gap reports 0
  always_comb begin
    nxt       = state;
    close     = 1'b0;
    start     = 1'b0;
    stall_hit = 1'b0;
    case (state)
      IDLE:    if (rise_c1) begin nxt = C1_ON; start = 1'b1; end else nxt = IDLE;
      C1_ON:   if (fall_c1) nxt = rise_c2 ? C2_ON : DT1; else nxt = C1_ON;
      DT1:     if (rise_c1) begin nxt = C1_ON; close = 1'b1; end
               else if (rise_c2) nxt = C2_ON;
               else nxt = DT1;
      C2_ON:   if (fall_c2 && rise_c1) begin nxt = C1_ON; close = 1'b1; end
               else if (fall_c2) nxt = DT2;
               else nxt = C2_ON;
      DT2:     if (rise_c1) begin nxt = C1_ON; close = 1'b1; end else nxt = DT2;
      default: nxt = IDLE;
    endcase
    if (!i_enable) begin
      nxt   = IDLE;
      close = 1'b0;
      start = 1'b0;
    end else if (state != IDLE && !close && period_cnt >= STALL_LIM) begin
      nxt       = IDLE;
      stall_hit = 1'b1;
    end else begin
      stall_hit = 1'b0;
    end
  end

  // The cycle that opens a period is counted as cycle 1 of its C1_ON phase
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      ton_cnt    <= 11'd0;
      dt1_cnt    <= 5'd0;
      dt2_cnt    <= 5'd0;
      period_cnt <= 12'd0;
    end else if (close || start) begin
      ton_cnt    <= 11'd1;
      dt1_cnt    <= 5'd0;
      dt2_cnt    <= 5'd0;
      period_cnt <= 12'd1;
    end else if (nxt == IDLE) begin
      ton_cnt    <= 11'd0;
      dt1_cnt    <= 5'd0;
      dt2_cnt    <= 5'd0;
      period_cnt <= 12'd0;
    end else begin
      if (period_cnt != 12'hFFF) period_cnt <= period_cnt + 12'd1;
      if (nxt == C1_ON && ton_cnt != 11'h7FF) ton_cnt <= ton_cnt + 11'd1;
      if (nxt == DT1 && dt1_cnt != 5'd31) dt1_cnt <= dt1_cnt + 5'd1;
      if (nxt == DT2 && dt2_cnt != 5'd31) dt2_cnt <= dt2_cnt + 5'd1;
    end
  end

  // Result, strobe and fault outputs; overlap set beats a same-cycle clear
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      o_ton     <= 11'd0;
      o_dt1     <= 5'd0;
      o_dt2     <= 5'd0;
      o_period  <= 12'd0;
      o_valid   <= 1'b0;
      o_overlap <= 1'b0;
      o_stall   <= 1'b0;
    end else begin
      o_valid <= close;
      if (close) begin
        o_ton    <= ton_cnt;
        o_dt1    <= dt1_cnt;
        o_dt2    <= dt2_cnt;
        o_period <= period_cnt;
      end
      if (stall_hit)  o_stall <= 1'b1;
      else if (close) o_stall <= 1'b0;
      if (s_c1 & s_c2)      o_overlap <= 1'b1;
      else if (i_clr_fault) o_overlap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dpwm_monitor.sv
`timescale 1ns/1ps
// Bench for dpwm_monitor: table vectors, random periods checked against an arithmetic
// period model, and hand sequences for stall, overlap, enable and reset.
module tb_dpwm_monitor;

  logic        clk = 1'b0;
  logic        reset, i_enable, i_c1, i_c2, i_clr_fault;
  logic [10:0] o_ton;
  logic [4:0]  o_dt1, o_dt2;
  logic [11:0] o_period;
  logic        o_valid, o_overlap, o_stall;

  dpwm_monitor #(.STALL_CYC(300)) dut (
    .i_clk(clk), .reset(reset), .i_enable(i_enable), .i_c1(i_c1), .i_c2(i_c2),
    .i_clr_fault(i_clr_fault), .o_ton(o_ton), .o_dt1(o_dt1), .o_dt2(o_dt2),
    .o_period(o_period), .o_valid(o_valid), .o_overlap(o_overlap), .o_stall(o_stall)
  );

  initial forever #2.5 clk = ~clk;

  typedef struct {
    int ton; int dt1; int c2w; int dt2; bit has_c2;
    int e_ton; int e_dt1; int e_dt2; int e_period;
  } vec_t;

  typedef struct { int cyc; int ton; int dt1; int dt2; int period; } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   armed    = 1'b0;
  exp_t prev;
  exp_t last_exp = '{default: 0};
  exp_t exp_q[$];
  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle check: strobe only where the model predicts it, results held elsewhere
  task automatic monitor();
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      chk("valid", int'(o_valid), 1);
      chk("ton", int'(o_ton), exp_q[0].ton);
      chk("dt1", int'(o_dt1), exp_q[0].dt1);
      chk("dt2", int'(o_dt2), exp_q[0].dt2);
      chk("period", int'(o_period), exp_q[0].period);
      last_exp = exp_q[0];
      void'(exp_q.pop_front());
    end else begin
      chk("no_valid", int'(o_valid), 0);
      chk("hold_ton", int'(o_ton), last_exp.ton);
      chk("hold_dt1", int'(o_dt1), last_exp.dt1);
      chk("hold_dt2", int'(o_dt2), last_exp.dt2);
      chk("hold_period", int'(o_period), last_exp.period);
    end
  endtask

  task automatic drive(input logic c1, input logic c2);
    i_c1 = c1;
    i_c2 = c2;
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  // A c1 rise driven now closes the previous period; its strobe is due two cycles later
  task automatic close_prev();
    exp_t e;
    if (armed) begin
      e = prev;
      e.cyc = cyc + 2;
      exp_q.push_back(e);
    end
  endtask

  task automatic gen_period(input int ton, input int dt1, input int c2w, input int dt2,
                            input bit has_c2, input int e_ton, input int e_dt1,
                            input int e_dt2, input int e_period);
    close_prev();
    prev = '{0, e_ton, e_dt1, e_dt2, e_period};
    armed = 1'b1;
    repeat (ton) drive(1'b1, 1'b0);
    repeat (dt1) drive(1'b0, 1'b0);
    if (has_c2) begin
      repeat (c2w) drive(1'b0, 1'b1);
      repeat (dt2) drive(1'b0, 1'b0);
    end
  endtask

  function automatic exp_t model(input int ton, input int dt1, input int c2w, input int dt2,
                                 input bit has_c2);
    exp_t r;
    r.cyc    = 0;
    r.ton    = ton;
    r.dt1    = (dt1 > 31) ? 31 : dt1;
    r.dt2    = has_c2 ? ((dt2 > 31) ? 31 : dt2) : 0;
    r.period = ton + dt1 + (has_c2 ? c2w + dt2 : 0);
    return r;
  endfunction

  task automatic chk_all(input string tag, input int ton, input int valid, input int ovl,
                         input int stall);
    chk({tag, "_ton"}, int'(o_ton), ton);
    chk({tag, "_dt1"}, int'(o_dt1), 0);
    chk({tag, "_dt2"}, int'(o_dt2), 0);
    chk({tag, "_period"}, int'(o_period), 0);
    chk({tag, "_valid"}, int'(o_valid), valid);
    chk({tag, "_overlap"}, int'(o_overlap), ovl);
    chk({tag, "_stall"}, int'(o_stall), stall);
  endtask

  initial begin
    int   r;
    exp_t m;

    tbl[0] = '{100, 5, 90, 7, 1'b1, 100, 5, 7, 202};
    tbl[1] = '{100, 5, 90, 7, 1'b1, 100, 5, 7, 202};
    tbl[2] = '{100, 5, 90, 7, 1'b1, 100, 5, 7, 202};
    tbl[3] = '{60, 40, 50, 0, 1'b1, 60, 31, 0, 150};
    tbl[4] = '{50, 20, 0, 0, 1'b0, 50, 20, 0, 70};
    tbl[5] = '{30, 0, 30, 3, 1'b1, 30, 0, 3, 63};
    tbl[6] = '{20, 31, 20, 32, 1'b1, 20, 31, 31, 103};
    tbl[7] = '{100, 5, 90, 7, 1'b1, 100, 5, 7, 202};

    reset = 1'b1; i_enable = 1'b1; i_c1 = 1'b0; i_c2 = 1'b0; i_clr_fault = 1'b0;
    repeat (3) drive(1'b0, 1'b0);
    chk_all("reset", 0, 0, 0, 0);
    reset = 1'b0;
    repeat (3) drive(1'b0, 1'b0);

    for (int i = 0; i < 8; i++)
      gen_period(tbl[i].ton, tbl[i].dt1, tbl[i].c2w, tbl[i].dt2, tbl[i].has_c2,
                 tbl[i].e_ton, tbl[i].e_dt1, tbl[i].e_dt2, tbl[i].e_period);

    for (int k = 0; k < 40; k++) begin
      int a, b, c, d;
      bit h;
      a = $urandom_range(80, 1);
      b = $urandom_range(40, 0);
      c = $urandom_range(80, 1);
      d = $urandom_range(40, 0);
      h = ($urandom_range(4, 0) != 32'd0);
      if (!h && b == 0) b = 1;
      m = model(a, b, c, d, h);
      gen_period(a, b, c, d, h, m.ton, m.dt1, m.dt2, m.period);
    end

    // Enable dropped mid-period: the period in flight is abandoned
    close_prev();
    armed = 1'b0;
    repeat (20) drive(1'b1, 1'b0);
    i_enable = 1'b0;
    repeat (10) drive(1'b1, 1'b0);
    i_enable = 1'b1;
    repeat (30) drive(1'b1, 1'b0);
    repeat (10) drive(1'b0, 1'b0);
    gen_period(100, 5, 90, 7, 1'b1, 100, 5, 7, 202);
    gen_period(80, 6, 70, 4, 1'b1, 80, 6, 4, 160);

    // Stall: c1 held low after the last rise
    r = cyc;
    gen_period(40, 10, 40, 10, 1'b1, 40, 10, 10, 100);
    armed = 1'b0;
    while (cyc < r + 310) begin
      drive(1'b0, 1'b0);
      chk("stall_timing", int'(o_stall), (cyc >= r + 302) ? 1 : 0);
    end
    gen_period(60, 4, 50, 6, 1'b1, 60, 4, 6, 120);
    chk("stall_held", int'(o_stall), 1);
    gen_period(60, 4, 50, 6, 1'b1, 60, 4, 6, 120);
    chk("stall_cleared", int'(o_stall), 0);

    // Overlap detection, stickiness, clear, and set-beats-clear (enable low throughout)
    armed = 1'b0;
    i_enable = 1'b0;
    repeat (3) drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    chk("ovl_early", int'(o_overlap), 0);
    drive(1'b0, 1'b0);
    chk("ovl_set", int'(o_overlap), 1);
    repeat (1000) drive(1'b0, 1'b0);
    chk("ovl_sticky", int'(o_overlap), 1);
    i_clr_fault = 1'b1;
    drive(1'b0, 1'b0);
    i_clr_fault = 1'b0;
    chk("ovl_clear", int'(o_overlap), 0);
    drive(1'b1, 1'b1);
    i_clr_fault = 1'b1;
    drive(1'b0, 1'b0);
    chk("ovl_set_wins", int'(o_overlap), 1);
    drive(1'b0, 1'b0);
    i_clr_fault = 1'b0;
    chk("ovl_clear2", int'(o_overlap), 0);
    i_enable = 1'b1;
    repeat (3) drive(1'b0, 1'b0);

    // Reset asserted mid-C2_ON
    gen_period(70, 8, 60, 9, 1'b1, 70, 8, 9, 147);
    gen_period(50, 3, 40, 2, 1'b1, 50, 3, 2, 95);
    close_prev();
    armed = 1'b0;
    repeat (30) drive(1'b1, 1'b0);
    repeat (3) drive(1'b0, 1'b0);
    repeat (10) drive(1'b0, 1'b1);
    #1;
    reset = 1'b1;
    last_exp = '{default: 0};
    #1;
    chk_all("midreset", 0, 0, 0, 0);
    repeat (3) drive(1'b0, 1'b0);
    reset = 1'b0;
    repeat (3) drive(1'b0, 1'b0);
    gen_period(70, 8, 60, 9, 1'b1, 70, 8, 9, 147);
    gen_period(45, 12, 35, 1, 1'b1, 45, 12, 1, 93);
    gen_period(100, 5, 90, 7, 1'b1, 100, 5, 7, 202);
    chk("pending_strobes", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
